// File: rtl/ram_read_arbiter.sv
// Round-robin arbiter that shares one RAM read channel among several requesters.
// Each granted request runs IDLE -> ISSUE -> WAIT -> DONE, ending in either masked data or a timeout error.
module ram_read_arbiter #(
    parameter int REQUESTERS = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2*REQUESTERS-1:0]    req_size,
    input  logic [32*REQUESTERS-1:0]   req_address,
    output logic [REQUESTERS-1:0]      req_accept,
    output logic [REQUESTERS-1:0]      resp_valid,
    output logic [31:0]                resp_data,
    output logic                       resp_error,
    output logic [31:0]                ram_address,
    output logic [1:0]                 ram_sig_read,
    input  logic [31:0]                ram_data,
    input  logic                       ram_is_ready,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    localparam int              IW          = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam logic [7:0]      TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [IW-1:0]   LAST_IDX    = IW'(REQUESTERS - 1);

    // dbg_state encoding: 0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [IW-1:0]           r_grant;
    logic [IW-1:0]           r_last_grant;
    logic [1:0]              r_size;
    logic [7:0]              r_wait_cnt;
    logic [REQUESTERS-1:0]   r_req_accept;
    logic [REQUESTERS-1:0]   r_resp_valid;
    logic [31:0]             r_resp_data;
    logic                    r_resp_error;
    logic [31:0]             r_ram_address;
    logic [1:0]              r_ram_sig_read;

    logic                    w_found;
    logic [IW-1:0]           w_pick;
    logic [1:0]              w_pick_size;
    logic [31:0]             w_pick_addr;
    logic [REQUESTERS-1:0]   w_pick_onehot;
    logic [REQUESTERS-1:0]   w_grant_onehot;
    logic [31:0]             w_masked;

    // Scan starts one past the last grant so every requester gets a turn.
    always_comb begin
        int idx;
        idx           = 0;
        w_found       = 1'b0;
        w_pick        = r_last_grant;
        w_pick_size   = 2'b00;
        w_pick_addr   = 32'd0;
        w_pick_onehot = '0;
        for (int i = 1; i <= REQUESTERS; i++) begin
            idx = int'(r_last_grant) + i;
            if (idx >= REQUESTERS) begin
                idx = idx - REQUESTERS;
            end
            if (!w_found && (2'(req_size >> (2 * idx)) != 2'b00)) begin
                w_found       = 1'b1;
                w_pick        = IW'(idx);
                w_pick_size   = 2'(req_size >> (2 * idx));
                w_pick_addr   = 32'(req_address >> (32 * idx));
                w_pick_onehot = REQUESTERS'(1) << idx;
            end
        end
    end

    always_comb begin
        w_grant_onehot = REQUESTERS'(1) << r_grant;
    end

    always_comb begin
        case (r_size)
            2'd1:    w_masked = {24'd0, ram_data[7:0]};
            2'd2:    w_masked = {16'd0, ram_data[15:0]};
            2'd3:    w_masked = ram_data;
            default: w_masked = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_grant        <= '0;
            r_last_grant   <= LAST_IDX;
            r_size         <= 2'b00;
            r_wait_cnt     <= 8'd0;
            r_req_accept   <= '0;
            r_resp_valid   <= '0;
            r_resp_data    <= 32'd0;
            r_resp_error   <= 1'b0;
            r_ram_address  <= 32'd0;
            r_ram_sig_read <= 2'b00;
        end else begin
            // Strobes are single-cycle; each state below raises them only for the next cycle.
            r_req_accept   <= '0;
            r_resp_valid   <= '0;
            r_ram_sig_read <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (ram_is_ready && w_found) begin
                        r_grant        <= w_pick;
                        r_size         <= w_pick_size;
                        r_ram_address  <= w_pick_addr;
                        r_ram_sig_read <= w_pick_size;
                        r_req_accept   <= w_pick_onehot;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= 8'd0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                    // Ready in the first WAIT cycle is stale: the RAM has not yet seen the strobe.
                    if ((r_wait_cnt != 8'd0) && ram_is_ready) begin
                        r_resp_data  <= w_masked;
                        r_resp_error <= 1'b0;
                        r_resp_valid <= w_grant_onehot;
                        r_state      <= S_DONE;
                    end else if ((r_wait_cnt + 8'd1) == TIMEOUT_CNT) begin
                        r_resp_data  <= 32'd0;
                        r_resp_error <= 1'b1;
                        r_resp_valid <= w_grant_onehot;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_last_grant <= r_grant;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_accept   = r_req_accept;
    assign resp_valid   = r_resp_valid;
    assign resp_data    = r_resp_data;
    assign resp_error   = r_resp_error;
    assign ram_address  = r_ram_address;
    assign ram_sig_read = r_ram_sig_read;
    assign busy         = (r_state != S_IDLE);
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Directed bench for ram_read_arbiter: two requesters, a small behavioural RAM, TIMEOUT=10.
// Expected values are hand-computed from the arbiter timing and the RAM model latency.
module tb_ram_read_arbiter;

    localparam int R  = 2;
    localparam int TO = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_size;
    logic [63:0] req_address;
    logic [1:0]  req_accept;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;
    logic [31:0] ram_address;
    logic [1:0]  ram_sig_read;
    logic [31:0] ram_data = 32'd0;
    logic        ram_is_ready;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int acc_count = 0;
    int rsp_count = 0;

    // RAM model: drops ready when it sees a strobe, returns data ram_latency+1 edges later.
    logic        ram_rdy_q     = 1'b1;
    int          ram_cnt       = 0;
    int          ram_latency   = 4;
    logic        ram_dead      = 1'b0;
    logic        ram_hold      = 1'b0;
    logic [31:0] ram_next_data = 32'd0;

    logic [1:0]  exp_q[$];

    ram_read_arbiter #(.REQUESTERS(R), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_size     (req_size),
        .req_address  (req_address),
        .req_accept   (req_accept),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_error   (resp_error),
        .ram_address  (ram_address),
        .ram_sig_read (ram_sig_read),
        .ram_data     (ram_data),
        .ram_is_ready (ram_is_ready),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ram_is_ready = ram_rdy_q & ~ram_hold;

    always @(posedge clk) begin
        if (ram_sig_read != 2'b00) begin
            ram_rdy_q <= 1'b0;
            ram_cnt   <= ram_latency;
        end else if (!ram_rdy_q) begin
            if (ram_cnt != 0) begin
                ram_cnt <= ram_cnt - 1;
            end else if (!ram_dead) begin
                ram_rdy_q <= 1'b1;
                ram_data  <= ram_next_data;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (req_accept != 2'b00) begin
            acc_count++;
            check("accept_onehot", 32'($onehot(req_accept)), 32'd1);
        end
        if (resp_valid != 2'b00) begin
            rsp_count++;
            check("resp_onehot", 32'($onehot(resp_valid)), 32'd1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [1:0] size, input logic [31:0] addr);
        if (i == 0) begin
            req_size[1:0]     = size;
            req_address[31:0] = addr;
        end else begin
            req_size[3:2]      = size;
            req_address[63:32] = addr;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_accept(output logic [1:0] acc, output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (req_accept == 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", 32'(req_accept != 2'b00), 32'd1);
        acc = req_accept;
        at  = cyc;
    endtask

    task automatic wait_resp(output logic [1:0] v, output logic [31:0] d, output logic e, output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (resp_valid == 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("resp_in_time", 32'(resp_valid != 2'b00), 32'd1);
        v  = resp_valid;
        d  = resp_data;
        e  = resp_error;
        at = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [1:0]  acc;
        logic [1:0]  v;
        logic [31:0] d;
        logic        e;
        logic [1:0]  g;
        int          t0, t1, t2, a0, r0, n;

        reset       = 1'b1;
        req_size    = '0;
        req_address = '0;
        repeat (2) @(negedge clk);
        check("rst_req_accept",   32'(req_accept),   32'd0);
        check("rst_resp_valid",   32'(resp_valid),   32'd0);
        check("rst_resp_data",    resp_data,         32'd0);
        check("rst_resp_error",   32'(resp_error),   32'd0);
        check("rst_ram_sig_read", 32'(ram_sig_read), 32'd0);
        check("rst_ram_address",  ram_address,       32'd0);
        check("rst_busy",         32'(busy),         32'd0);
        check("rst_state_idle",   32'(dbg_state),    32'd0);
        reset = 1'b0;

        // Single word read on requester 0, RAM latency 4.
        ram_latency   = 4;
        ram_next_data = 32'hDEADBEEF;
        set_req(0, 2'd3, 32'h100);
        wait_accept(acc, t0);
        check("word_accept",   32'(acc),          32'h1);
        check("word_sig_read", 32'(ram_sig_read), 32'd3);
        check("word_address",  ram_address,       32'h100);
        set_req(0, 2'd0, 32'h0);
        wait_resp(v, d, e, t1);
        check("word_valid",   32'(v),    32'h1);
        check("word_data",    d,         32'hDEADBEEF);
        check("word_error",   32'(e),    32'd0);
        check("word_latency", 32'(t1 - t0), 32'd7);
        @(negedge clk);
        check("word_idle_busy",   32'(busy),         32'd0);
        check("word_sig_cleared", 32'(ram_sig_read), 32'd0);
        check("word_addr_holds",  ram_address,       32'h100);

        // Byte read on requester 1.
        ram_next_data = 32'h123456AB;
        set_req(1, 2'd1, 32'h101);
        wait_accept(acc, t0);
        check("byte_accept",   32'(acc),          32'h2);
        check("byte_sig_read", 32'(ram_sig_read), 32'd1);
        set_req(1, 2'd0, 32'h0);
        wait_resp(v, d, e, t1);
        check("byte_valid", 32'(v), 32'h2);
        check("byte_data",  d,      32'h000000AB);

        // Halfword read on requester 0.
        ram_next_data = 32'hCAFEBABE;
        set_req(0, 2'd2, 32'h202);
        wait_accept(acc, t0);
        check("half_accept", 32'(acc), 32'h1);
        set_req(0, 2'd0, 32'h0);
        wait_resp(v, d, e, t1);
        check("half_valid", 32'(v), 32'h1);
        check("half_data",  d,      32'h0000BABE);

        // Requester 1 raises its request during requester 0's ISSUE.
        ram_next_data = 32'h11223344;
        set_req(0, 2'd3, 32'h400);
        wait_accept(acc, t0);
        check("late_first_accept", 32'(acc), 32'h1);
        set_req(0, 2'd0, 32'h0);
        set_req(1, 2'd3, 32'h500);
        wait_resp(v, d, e, t1);
        check("late_first_valid", 32'(v), 32'h1);
        wait_accept(acc, t2);
        check("late_second_accept", 32'(acc),     32'h2);
        check("late_back_to_back",  32'(t2 - t1), 32'd2);
        check("late_second_addr",   ram_address,  32'h500);
        set_req(1, 2'd0, 32'h0);
        wait_resp(v, d, e, t1);
        check("late_second_valid", 32'(v), 32'h2);
        check("late_second_data",  d,      32'h11223344);

        // RAM never becomes ready: timeout after 10 WAIT cycles.
        ram_dead = 1'b1;
        set_req(0, 2'd3, 32'h600);
        wait_accept(acc, t0);
        set_req(0, 2'd0, 32'h0);
        wait_resp(v, d, e, t1);
        check("tmo_valid",   32'(v),        32'h1);
        check("tmo_error",   32'(e),        32'd1);
        check("tmo_data",    d,             32'd0);
        check("tmo_latency", 32'(t1 - t0),  32'd11);
        @(negedge clk);
        check("tmo_state_idle", 32'(dbg_state), 32'd0);
        check("tmo_busy",       32'(busy),      32'd0);
        ram_dead = 1'b0;
        repeat (3) @(negedge clk);

        // Both requesters hold continuous word reads: grants alternate from 0.
        do_reset();
        a0 = acc_count;
        r0 = rsp_count;
        ram_next_data = 32'h0BADF00D;
        for (int k = 0; k < 6; k++) exp_q.push_back(2'(k % 2));
        set_req(0, 2'd3, 32'h700);
        set_req(1, 2'd3, 32'h800);
        for (int k = 0; k < 6; k++) begin
            wait_accept(acc, t0);
            g = exp_q.pop_front();
            check("rr_grant", 32'(acc), 32'(2'b01 << g));
            if (k == 5) begin
                set_req(0, 2'd0, 32'h0);
                set_req(1, 2'd0, 32'h0);
            end
            wait_resp(v, d, e, t1);
            check("rr_resp_index", 32'(v), 32'(2'b01 << g));
            check("rr_resp_data",  d,      32'h0BADF00D);
        end
        repeat (3) @(negedge clk);
        check("rr_accept_count", 32'(acc_count - a0), 32'd6);
        check("rr_resp_count",   32'(rsp_count - r0), 32'd6);

        // Reset during WAIT while the RAM stays busy; requester 1 pending.
        ram_latency   = 6;
        ram_next_data = 32'h89ABCDEF;
        r0 = rsp_count;
        set_req(0, 2'd3, 32'h900);
        wait_accept(acc, t0);
        check("rstw_first_accept", 32'(acc), 32'h1);
        set_req(0, 2'd0, 32'h0);
        set_req(1, 2'd2, 32'hA00);
        repeat (2) @(negedge clk);
        reset    = 1'b1;
        ram_hold = 1'b1;
        @(negedge clk);
        check("rstw_busy_cleared", 32'(busy),       32'd0);
        check("rstw_no_resp",      32'(resp_valid), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rstw_no_grant_hold", 32'(req_accept), 32'd0);
            check("rstw_no_resp_hold",  32'(resp_valid), 32'd0);
        end
        ram_hold = 1'b0;
        n = 0;
        while (!ram_is_ready && n < 50) begin
            check("rstw_no_grant_busy_ram", 32'(req_accept), 32'd0);
            @(negedge clk);
            n++;
        end
        wait_accept(acc, t0);
        check("rstw_accept_req1", 32'(acc),          32'h2);
        check("rstw_addr",        ram_address,       32'hA00);
        check("rstw_sig_read",    32'(ram_sig_read), 32'd2);
        set_req(1, 2'd0, 32'h0);
        wait_resp(v, d, e, t1);
        check("rstw_valid", 32'(v), 32'h2);
        check("rstw_data",  d,      32'h0000CDEF);
        check("rstw_error", 32'(e), 32'd0);
        repeat (3) @(negedge clk);
        check("rstw_resp_count", 32'(rsp_count - r0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_read_arbiter.md
RAM_READ_ARBITER -- requirements
Module: ram_read_arbiter

Interface
REQ-001 Parameter REQUESTERS, default 2, number of requester ports sharing one RAM read channel (2..8).
REQ-002 Parameter TIMEOUT, default 255, maximum WAIT cycles before a request is aborted (1..255).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_size  input  2*REQUESTERS  per-requester read size: 0 none, 1 byte, 2 halfword, 3 word; held nonzero until accepted.
REQ-006 req_address  input  32*REQUESTERS  per-requester byte address, valid while req_size nonzero.
REQ-007 req_accept  output  REQUESTERS  one-cycle pulse: request captured, requester may drop req_size.
REQ-008 resp_valid  output  REQUESTERS  one-cycle pulse: resp_data/resp_error valid for that requester.
REQ-009 resp_data  output  32  read data, little-endian, unused upper bytes zero.
REQ-010 resp_error  output  1  qualifies resp_valid: 1 = timed out, resp_data is 0.
REQ-011 ram_address  output  32  to RAM read channel address.
REQ-012 ram_sig_read  output  2  to RAM read channel size strobe.
REQ-013 ram_data  input  32  from RAM read channel data.
REQ-014 ram_is_ready  input  1  from RAM read channel; 1 = idle and previous data valid.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, DONE; registered outputs only.
REQ-017 IDLE: if ram_is_ready=1 and any req_size nonzero, grant the first requesting index after last_grant (round-robin, wrap at REQUESTERS-1 to 0); latch grant index, address, size; -> ISSUE. Otherwise stay.
REQ-018 IDLE with ram_is_ready=0 shall not grant (covers RAM still busy after arbiter reset).
REQ-019 ISSUE (exactly 1 cycle): ram_sig_read = latched size, ram_address = latched address, req_accept[grant]=1; -> WAIT, clear WAIT counter.
REQ-020 ram_sig_read shall be 0 in every state except ISSUE; ram_address holds last value outside ISSUE.
REQ-021 WAIT: first cycle ignores ram_is_ready (RAM capture latency); thereafter ram_is_ready=1 -> latch ram_data masked by size (byte [7:0], halfword [15:0], word [31:0]) -> DONE.
REQ-022 WAIT counter 8-bit, increments each WAIT cycle; reaching TIMEOUT without ready -> resp_error latched 1, data 0 -> DONE.
REQ-023 DONE (1 cycle): resp_valid[grant]=1, resp_data/resp_error driven; last_grant <= grant; -> IDLE.
REQ-024 Request-to-response minimum latency: grant edge to resp_valid = 3 + RAM access cycles; back-to-back grant possible in the cycle after DONE.
REQ-025 Requests arriving during ISSUE/WAIT/DONE stay pending and are arbitrated in IDLE; no request is lost or accepted twice.
REQ-026 A requester dropping req_size before req_accept is simply not granted; no output effect.
REQ-027 Simultaneous requests: exactly one req_accept bit per grant; one-hot resp_valid.
REQ-028 Out-of-range size values cannot occur (2-bit); size 0 never granted.

Reset
REQ-029 reset=1 at a clock edge: state IDLE, req_accept 0, resp_valid 0, resp_data 0, resp_error 0, ram_sig_read 0, ram_address 0, busy 0, WAIT counter 0, last_grant REQUESTERS-1 (requester 0 wins first).
REQ-030 Reset mid-transaction abandons it without resp_valid; next grant waits for ram_is_ready=1 per REQ-018.

Verification
REQ-031 Single word read: req_size[1:0]=3, addr 0x100, RAM returns 0xDEADBEEF after 4 cycles -> one req_accept[0] pulse, one resp_valid[0] with 0xDEADBEEF, resp_error 0.
REQ-032 Byte read masking: size 1, RAM returns 0x123456AB -> resp_data 0x000000AB.
REQ-033 Both requesters hold continuous word reads for 6 transactions -> grants alternate 0,1,0,1,0,1, each accepted once.
REQ-034 RAM model never asserts ready, TIMEOUT=10 -> resp_valid with resp_error 1, data 0 after 10 WAIT cycles; arbiter returns to IDLE.
REQ-035 Reset asserted during WAIT with ram_is_ready=0 for 3 more cycles, requester 1 pending -> no resp_valid, no grant until ram_is_ready=1, then req_accept[1].
REQ-036 Request raised on requester 1 during ISSUE of requester 0 -> serviced immediately after requester 0's DONE.
